// File: rtl/rd_wait_pkg.sv
// Shared definitions for the rd/ws wait-state read handshake.
// The responder uses them here, and the initiator side uses the same package.
package rd_wait_pkg;

  localparam int AW_DEF  = 4;
  localparam int DW_DEF  = 8;
  localparam int WSW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DATA = 2'b10
  } rd_state_e;

endpackage

// File: rtl/rd_resp_mem.sv
// Small register file with one synchronous write port and one asynchronous read port.
module rd_resp_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  // NOTE: the storage array has no reset on purpose. Resetting it would
  // force every word into a flop with a reset pin instead of plain storage.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rd_wait_responder.sv
// Target-side rd/ws responder: inserts cfg_wait wait states, then returns one word with rvalid.
// The FSM, wait counter, captured address and all outputs are registered here.
module rd_wait_responder
  import rd_wait_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int WSW = WSW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rd,
  input  logic [AW-1:0]  addr,
  input  logic [WSW-1:0] cfg_wait,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [DW-1:0]  wdata,
  output logic           ws,
  output logic           rvalid,
  output logic [DW-1:0]  rdata,
  output logic           busy
);

  rd_state_e      state_q, state_d;
  logic [WSW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           ws_q, rvalid_q, busy_q;
  logic [DW-1:0]  rdata_q;

  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  mem_word;
  logic [DW-1:0]  load_word;

  // NOTE: every signal written in this block gets a default first, so no
  // path through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (rd) begin
          addr_d  = addr;
          cnt_d   = cfg_wait;
          state_d = (cfg_wait == '0) ? DATA : WAIT;
        end
      end
      WAIT: begin
        if (!rd) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == WSW'(1)) begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A zero-wait read goes straight from IDLE to DATA, before addr_q holds the address.
  assign rd_addr = (state_q == IDLE) ? addr : addr_q;

  rd_resp_mem #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (mem_word)
  );

  // A write that commits on the same edge that enters DATA must show up in the returned word.
  assign load_word = (we && (waddr == rd_addr)) ? wdata : mem_word;

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      ws_q     <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      ws_q     <= (state_d == WAIT);
      rvalid_q <= (state_d == DATA);
      busy_q   <= (state_d != IDLE);
      if (state_d == DATA) begin
        rdata_q <= load_word;
      end
    end
  end

  assign ws     = ws_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;
  assign rdata  = rdata_q;

endmodule
